// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// | Package     : uart_pkg                                                  |
// | Description : Shared UART definitions for the 8N1 receiver and sender. |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Clocks per bit; integer division, so CLK_HZ should be a near multiple of the baud rate.
  function automatic int baud_div(input int clk_hz, input int baudrate);
    return clk_hz / baudrate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_8n1.sv
// ---------------------------------------------------------------------------
// | Module      : uart_rx_8n1                                               |
// | Description : 8N1 serial receiver with 2-FF input synchronizer.        |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_8n1 #(
  parameter int CLK_HZ   = 25_000_000,
  parameter int BAUDRATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);
  import uart_pkg::*;

  localparam int c_div   = baud_div(CLK_HZ, BAUDRATE);
  localparam int c_cnt_w = $clog2(c_div);
  localparam int c_idx_w = $clog2(UART_DATA_BITS);

  localparam logic [c_cnt_w-1:0] c_half     = c_cnt_w'(c_div / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(c_div - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_idx_w-1:0] c_last_bit = c_idx_w'(UART_DATA_BITS - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

  localparam logic [1:0] c_st_idle  = IDLE;
  localparam logic [1:0] c_st_start = START;
  localparam logic [1:0] c_st_data  = DATA;
  localparam logic [1:0] c_st_stop  = STOP;

  logic [1:0]               r_sync;
  logic                     r_rx_d;
  logic [1:0]               r_state;
  logic [c_cnt_w-1:0]       r_cnt;
  logic [c_idx_w-1:0]       r_idx;
  logic [7:0]               r_shift;
  logic [7:0]               r_byte;
  logic                     r_valid;
  logic                     r_ferr;

  logic w_rx;
  logic w_fall;
  logic w_tick;

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_d & ~w_rx;
  assign w_tick = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= 2'b11;
      r_rx_d  <= 1'b1;
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_rx_d  <= w_rx;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_fall) begin
            r_cnt   <= c_half;
            r_state <= c_st_start;
          end
        end
        c_st_start: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else if (!w_rx) begin
            r_cnt   <= c_full;
            r_idx   <= '0;
            r_state <= c_st_data;
          end else begin
            r_state <= c_st_idle;
          end
        end
        c_st_data: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_cnt   <= c_full;
            r_idx   <= r_idx + c_idx_one;
            if (r_idx == c_last_bit) r_state <= c_st_stop;
          end
        end
        c_st_stop: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else begin
            // Return to IDLE at mid stop bit so a following start edge is never missed.
            if (w_rx) begin
              r_byte  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign rx_byte   = r_byte;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;

endmodule

`default_nettype wire

// File: rtl/uart_rx_word_loader.sv
// ---------------------------------------------------------------------------
// | Module      : uart_rx_word_loader                                       |
// | Description : UART receiver packing little-endian bytes into 32-bit    |
// |               program-memory writes at an auto-incrementing address.   |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_word_loader #(
  parameter int CLK_HZ       = 25_000_000,
  parameter int BAUDRATE     = 9600,
  parameter int ADDR_W       = 13,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX,
  input  logic              load_en,
  output logic [7:0]        rx_byte,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic              full
);
  import uart_pkg::*;

  localparam int c_div     = baud_div(CLK_HZ, BAUDRATE);
  localparam int c_to_lim  = TIMEOUT_BITS * c_div;
  localparam int c_to_w    = $clog2(c_to_lim + 1);

  localparam logic [c_to_w-1:0] c_to_max = c_to_w'(c_to_lim);
  localparam logic [c_to_w-1:0] c_to_one = c_to_w'(1);
  localparam logic [ADDR_W-1:0] c_wa_max = '1;
  localparam logic [ADDR_W-1:0] c_wa_one = ADDR_W'(1);

  logic [1:0]        r_byte_cnt;
  logic [c_to_w-1:0] r_to_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_wa;
  logic [31:0]       r_wd;
  logic              r_full;

  uart_rx_8n1 #(
    .CLK_HZ   (CLK_HZ),
    .BAUDRATE (BAUDRATE)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (RX),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt <= '0;
      r_to_cnt   <= '0;
      r_we       <= 1'b0;
      r_wa       <= '0;
      r_wd       <= '0;
      r_full     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (!load_en) begin
        // Dropping load_en also cancels a word whose 4th byte lands this cycle.
        r_byte_cnt <= '0;
        r_to_cnt   <= '0;
        r_wa       <= '0;
        r_full     <= 1'b0;
      end else begin
        if (r_we) begin
          if (r_wa == c_wa_max) r_full <= 1'b1;
          else                  r_wa   <= r_wa + c_wa_one;
        end
        if (rx_valid && !r_full) begin
          r_wd[{r_byte_cnt, 3'b000} +: 8] <= rx_byte;
          r_byte_cnt <= r_byte_cnt + 2'd1;
          r_to_cnt   <= '0;
          if (r_byte_cnt == 2'd3) r_we <= 1'b1;
        end else if (frame_err) begin
          r_byte_cnt <= '0;
          r_to_cnt   <= '0;
        end else if (r_byte_cnt != 2'd0) begin
          if (r_to_cnt == c_to_max) begin
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + c_to_one;
          end
        end
      end
    end
  end

  assign we   = r_we;
  assign wa   = r_wa;
  assign wd   = r_wd;
  assign full = r_full;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_word_loader.sv
// ---------------------------------------------------------------------------
// | Module      : tb_uart_rx_word_loader                                    |
// | Description : Directed table-driven bench for uart_rx_word_loader.     |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_word_loader;

  localparam int BIT_CLKS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic        rx2 = 1'b1;
  logic        load_en  = 1'b1;
  logic        load_en2 = 1'b1;

  logic [7:0]  rx_byte,  rx_byte2;
  logic        rx_valid, rx_valid2;
  logic        frame_err, frame_err2;
  logic        we, we2;
  logic [12:0] wa;
  logic [1:0]  wa2;
  logic [31:0] wd, wd2;
  logic        full, full2;

  always #5 clk = ~clk;

  uart_rx_word_loader #(
    .CLK_HZ(25_000_000), .BAUDRATE(1_562_500), .ADDR_W(13), .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk), .rst(rst), .RX(rx), .load_en(load_en),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err),
    .we(we), .wa(wa), .wd(wd), .full(full)
  );

  uart_rx_word_loader #(
    .CLK_HZ(25_000_000), .BAUDRATE(1_562_500), .ADDR_W(2), .TIMEOUT_BITS(20)
  ) dut2 (
    .clk(clk), .rst(rst), .RX(rx2), .load_en(load_en2),
    .rx_byte(rx_byte2), .rx_valid(rx_valid2), .frame_err(frame_err2),
    .we(we2), .wa(wa2), .wd(wd2), .full(full2)
  );

  // Event monitor, sampled on the falling edge.
  int          cyc = 0;
  int          n_rxv = 0, n_fe = 0, n_we = 0, n_we2 = 0;
  int          rxv_cyc = 0, we_cyc = 0;
  logic [12:0] we_wa_last = '0;
  logic [31:0] we_wd_last = '0;
  logic [31:0] we2_wd_last = '0;
  logic [1:0]  we2_addr [8];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_valid)  begin n_rxv = n_rxv + 1; rxv_cyc = cyc; end
    if (frame_err) n_fe = n_fe + 1;
    if (we) begin
      n_we = n_we + 1; we_cyc = cyc; we_wa_last = wa; we_wd_last = wd;
    end
    if (we2) begin
      if (n_we2 < 8) we2_addr[n_we2] = wa2;
      n_we2 = n_we2 + 1; we2_wd_last = wd2;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx2 = v;
    else     rx  = v;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit sel);
    drive(sel, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      repeat (BIT_CLKS) @(negedge clk);
    end
    drive(sel, stop);
    repeat (BIT_CLKS) @(negedge clk);
    drive(sel, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        stop;
    logic        le;
    int          rxv;
    int          fe;
    int          wev;
    logic [7:0]  byte_now;
    logic [12:0] wa_now;
    logic [12:0] we_wa;
    logic [31:0] we_wd;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int r0, f0, w0;

    tbl[0]  = '{8'h78, 1'b1, 1'b1, 1, 0, 0, 8'h78, 13'd0, 13'd0, 32'h0};
    tbl[1]  = '{8'h56, 1'b1, 1'b1, 1, 0, 0, 8'h56, 13'd0, 13'd0, 32'h0};
    tbl[2]  = '{8'h34, 1'b1, 1'b1, 1, 0, 0, 8'h34, 13'd0, 13'd0, 32'h0};
    tbl[3]  = '{8'h12, 1'b1, 1'b1, 1, 0, 1, 8'h12, 13'd1, 13'd0, 32'h12345678};
    tbl[4]  = '{8'h5A, 1'b1, 1'b0, 1, 0, 0, 8'h5A, 13'd0, 13'd0, 32'h0};
    tbl[5]  = '{8'hAA, 1'b1, 1'b1, 1, 0, 0, 8'hAA, 13'd0, 13'd0, 32'h0};
    tbl[6]  = '{8'hBB, 1'b0, 1'b1, 0, 1, 0, 8'hAA, 13'd0, 13'd0, 32'h0};
    tbl[7]  = '{8'h11, 1'b1, 1'b1, 1, 0, 0, 8'h11, 13'd0, 13'd0, 32'h0};
    tbl[8]  = '{8'h22, 1'b1, 1'b1, 1, 0, 0, 8'h22, 13'd0, 13'd0, 32'h0};
    tbl[9]  = '{8'h33, 1'b1, 1'b1, 1, 0, 0, 8'h33, 13'd0, 13'd0, 32'h0};
    tbl[10] = '{8'h44, 1'b1, 1'b1, 1, 0, 1, 8'h44, 13'd1, 13'd0, 32'h44332211};

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_rx_byte",  {24'h0, rx_byte}, 32'h0);
    chk("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_we",       {31'h0, we}, 32'h0);
    chk("rst_wa",       {19'h0, wa}, 32'h0);
    chk("rst_wd",       wd, 32'h0);
    chk("rst_full",     {31'h0, full}, 32'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_frame_err", {31'h0, frame_err}, 32'h0);

    // Frames with per-vector expectations: word assembly, load_en=0 clear, framing error
    for (int i = 0; i < 11; i++) begin
      load_en = tbl[i].le;
      r0 = n_rxv; f0 = n_fe; w0 = n_we;
      send_frame(tbl[i].d, tbl[i].stop, 1'b0);
      chk($sformatf("v%0d_rx_valid", i), n_rxv - r0, tbl[i].rxv);
      chk($sformatf("v%0d_frame_err", i), n_fe - f0, tbl[i].fe);
      chk($sformatf("v%0d_we_count", i), n_we - w0, tbl[i].wev);
      chk($sformatf("v%0d_rx_byte", i), {24'h0, rx_byte}, {24'h0, tbl[i].byte_now});
      chk($sformatf("v%0d_wa", i), {19'h0, wa}, {19'h0, tbl[i].wa_now});
      if (tbl[i].wev != 0) begin
        chk($sformatf("v%0d_we_wa", i), {19'h0, we_wa_last}, {19'h0, tbl[i].we_wa});
        chk($sformatf("v%0d_we_wd", i), we_wd_last, tbl[i].we_wd);
      end
    end

    // Short low glitch while idle is a false start
    load_en = 1'b0;
    r0 = n_rxv; f0 = n_fe;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("glitch_rx_valid", n_rxv - r0, 0);
    chk("glitch_frame_err", n_fe - f0, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    chk("glitch_next_valid", n_rxv - r0, 1);
    chk("glitch_next_byte", {24'h0, rx_byte}, 32'h3C);

    // Partial word timeout
    load_en = 1'b1;
    w0 = n_we;
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    repeat (21 * BIT_CLKS) @(negedge clk);
    send_frame(8'hA1, 1'b1, 1'b0);
    send_frame(8'hB2, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    send_frame(8'hD4, 1'b1, 1'b0);
    chk("timeout_we_count", n_we - w0, 1);
    chk("timeout_we_wa", {19'h0, we_wa_last}, 32'h0);
    chk("timeout_we_wd", we_wd_last, 32'hD4C3B2A1);
    chk("we_latency", we_cyc - rxv_cyc, 1);
    chk("timeout_wa_after", {19'h0, wa}, 32'h1);

    // Small address space fills and stops writing
    for (int i = 0; i < 20; i++) send_frame(8'(i), 1'b1, 1'b1);
    chk("wrap_we_count", n_we2, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("wrap_addr%0d", i), {30'h0, we2_addr[i]}, 32'(i));
    chk("wrap_last_wd", we2_wd_last, 32'h0F0E0D0C);
    chk("wrap_full", {31'h0, full2}, 32'h1);
    chk("wrap_wa_hold", {30'h0, wa2}, 32'h3);

    // Reset in the middle of data bit 4
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_rx_byte", {24'h0, rx_byte}, 32'h0);
    chk("midrst_wa", {19'h0, wa}, 32'h0);
    chk("midrst_wd", wd, 32'h0);
    chk("midrst_full2", {31'h0, full2}, 32'h0);
    rst = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    r0 = n_rxv;
    send_frame(8'hC3, 1'b1, 1'b0);
    chk("midrst_next_valid", n_rxv - r0, 1);
    chk("midrst_next_byte", {24'h0, rx_byte}, 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
